fsm_stim_driver: RTL and testbench
==================================

Name: fsm_stim_driver

Overview:
Stimulus-side partner of the x/y/z Moore controller (state codes S7=0, S1=1, S5=2, S6=3, S9=4, S10=5, ERROR=7).
- Accepts a requested target state over a valid/ready handshake.
- Resets the controller, then drives the x/y sequence that steers it to the target.
- Compares the controller's z each cycle against the expected value and reports done/pass.
- Sits between the test/control logic and the controller's x, y, rst and z pins.

Parameters:
RST_PULSE, 1, cycles fsm_rst is held high per request (legal range 1..15).
Z_W, 3, width of controller output z.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
req_valid  input  1  target request valid
req_ready  output  1  driver idle, request accepted when valid&ready
req_target  input  3  target state code
fsm_rst  output  1  reset to controller
fsm_x  output  1  controller x input
fsm_y  output  1  controller y input
fsm_z  input  Z_W  controller z output
done  output  1  one-cycle completion pulse
pass  output  1  valid with done: all z checks matched
bad_target  output  1  valid with done: target code not in {0,1,2,3,4,5}
err_step  output  2  valid with done when pass=0: index of first mismatching check

Behaviour:
Reset values (while rst=1 and on the first cycle after):
- req_ready=0, fsm_rst=1 (controller held in reset), fsm_x=0, fsm_y=0.
- done=0, pass=0, bad_target=0, err_step=0; FSM returns to IDLE.
- req_ready rises the cycle after rst deasserts.

Controller model (decided):
- S7: y=0 stays; y=1,x=0 goes to S10; y=1,x=1 goes to S9.
- S10 goes to S5.
- S5: y=1 goes to S1; y=0,x=1 goes to S9; y=0,x=0 goes to S6.
- S6 goes to S1.
- S1 and S9 are absorbing.
- z values: S7=0, S10=0, S5=1, S9=1, S6=2, S1=5.

Paths, as (x,y) per step:
- S7: none.
- S10: (0,1).
- S9: (1,1).
- S5: (0,1),(0,0).
- S6: (0,1),(0,0),(0,0).
- S1: (0,1),(0,0),(0,1).
- N = path length (0..3).

States and transitions:
- IDLE: req_ready=1, x=y=0, fsm_rst=0. Accept at cycle T; latch target.
  - Bad code: go to DONE with pass=0, bad_target=1, no fsm_rst.
  - Valid code: go to RESET.
- RESET: fsm_rst=1 for RST_PULSE cycles, x=y=0. Then go to STEP if N>0, else CHECK.
- STEP k (k=0..N-1): drive path[k].
  - Compare fsm_z with z of the expected current state (S7 at k=0).
  - On the first mismatch, record err_step=k.
  - After step N-1, go to CHECK.
- CHECK: x=y=0. Compare fsm_z with z(target); a mismatch here with none earlier gives err_step=N (S7 target: 0).
- DONE: done=1 for one cycle with pass/bad_target/err_step; req_ready=0; then IDLE.

Timing and handshake:
- Latency from acceptance: done at cycle T+2+RST_PULSE+N. Bad target: done at T+1.
- req_ready is high only in IDLE.
- A request held valid through DONE is accepted in the following IDLE cycle.
- rst mid-operation aborts immediately: no done pulse, all outputs return to reset values.
- pass, bad_target and err_step are held after DONE until the next acceptance; done is pulsed only.

Optional Feature:
FSM_DRV_ZCHECK_EN
- Defined: z comparisons as above.
- Undefined: the comparator is removed and fsm_z is unused. pass=1 for any valid target and err_step=0; bad_target behaviour is unchanged.

Decomposition:
- Package fsm_pkg holds:
  - state-code localparams (S7, S1, S5, S6, S9, S10, ERROR);
  - z-value constants;
  - driver-state enum typedef (IDLE, RESET, STEP, CHECK, DONE);
  - path length constant MAX_STEPS=3.
- One sub-module, fsm_path_rom: combinational lookup of (target, step) to {x, y, expected_z, valid_target, N}. Instantiated once.

Test Plan:
- Target S1 (1), controller model attached, RST_PULSE=1 -> x/y = 01,00,01 on T+2..T+4; done at T+6, pass=1, bad_target=0.
- Target S6 (3), controller z forced to 0 during the check at step 2 -> done at T+6, pass=0, err_step=2.
- Target 7 -> done at T+1, bad_target=1, pass=0, fsm_rst never asserted.
- Target S7 (0) with RST_PULSE=4 -> fsm_rst high T+1..T+4, CHECK at T+5 sees z=0, done at T+6, pass=1.
- rst asserted during STEP 1 of an S5 request -> next cycle fsm_rst=1, x=y=0, no done; a new S9 request after reset completes with pass=1.
- Back-to-back: req_valid held high with S10 then S9 -> second acceptance exactly one cycle after the first done; both pass=1.

Source files
------------

// File: rtl/fsm_pkg.sv
// rtl/fsm_pkg.sv - shared state codes, z values and driver state enum for the x/y/z stimulus driver
package fsm_pkg;

    localparam logic [2:0] S7    = 3'd0;
    localparam logic [2:0] S1    = 3'd1;
    localparam logic [2:0] S5    = 3'd2;
    localparam logic [2:0] S6    = 3'd3;
    localparam logic [2:0] S9    = 3'd4;
    localparam logic [2:0] S10   = 3'd5;
    localparam logic [2:0] ERROR = 3'd7;

    localparam logic [2:0] Z_S7  = 3'd0;
    localparam logic [2:0] Z_S10 = 3'd0;
    localparam logic [2:0] Z_S5  = 3'd1;
    localparam logic [2:0] Z_S9  = 3'd1;
    localparam logic [2:0] Z_S6  = 3'd2;
    localparam logic [2:0] Z_S1  = 3'd5;

    localparam int MAX_STEPS = 3;

    typedef enum logic [2:0] {
        IDLE,
        RESET,
        STEP,
        CHECK,
        DONE
    } drv_state_t;

    function automatic logic [2:0] z_of(input logic [2:0] s);
        case (s)
            S7:      z_of = Z_S7;
            S10:     z_of = Z_S10;
            S5:      z_of = Z_S5;
            S9:      z_of = Z_S9;
            S6:      z_of = Z_S6;
            S1:      z_of = Z_S1;
            default: z_of = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/fsm_path_rom.sv
// rtl/fsm_path_rom.sv - combinational (target, step) lookup of x/y drive, expected z, target validity and path length
module fsm_path_rom
    import fsm_pkg::*;
(
    input  logic [2:0] target,
    input  logic [1:0] step,
    output logic       x,
    output logic       y,
    output logic [2:0] exp_z,
    output logic       valid_target,
    output logic [1:0] n
);

    logic [2:0] st;

    always_comb begin
        x            = 1'b0;
        y            = 1'b0;
        valid_target = 1'b1;
        n            = 2'd0;
        case (target)
            S7:  n = 2'd0;
            S9:  begin n = 2'd1; x = (step == 2'd0); y = (step == 2'd0); end
            S10: begin n = 2'd1; y = (step == 2'd0); end
            S5:  begin n = 2'd2; y = (step == 2'd0); end
            S6:  begin n = 2'd3; y = (step == 2'd0); end
            S1:  begin n = 2'd3; y = (step == 2'd0) || (step == 2'd2); end
            default: valid_target = 1'b0;
        endcase

        // Every multi-step path walks S7 -> S10 -> S5 before branching
        st = target;
        if (step < n) begin
            case (step)
                2'd0:    st = S7;
                2'd1:    st = S10;
                default: st = S5;
            endcase
        end
        exp_z = z_of(st);
    end

endmodule

// File: rtl/fsm_stim_driver.sv
// rtl/fsm_stim_driver.sv - resets the x/y/z controller, steers it to a requested state and checks z; FSM_DRV_ZCHECK_EN enables z checking
module fsm_stim_driver
    import fsm_pkg::*;
#(
    parameter int RST_PULSE = 1,
    parameter int Z_W       = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [2:0]     req_target,
    output logic           fsm_rst,
    output logic           fsm_x,
    output logic           fsm_y,
    input  logic [Z_W-1:0] fsm_z,
    output logic           done,
    output logic           pass,
    output logic           bad_target,
    output logic [1:0]     err_step
);

    drv_state_t state, state_n;
    logic       init_q;
    logic [2:0] target_q;
    logic [3:0] cnt_q;
    logic [1:0] step_q;
    logic       mism_q;
    logic       pass_q;
    logic       bad_q;
    logic [1:0] err_q;

    logic [2:0] rom_target;
    logic       rom_x, rom_y, rom_valid;
    logic [2:0] rom_z;
    logic [1:0] rom_n;
    logic       accept;
    logic       z_mis;

    // The target is validated straight off the request bus while idle
    assign rom_target = (state == IDLE) ? req_target : target_q;

    fsm_path_rom u_path_rom (
        .target       (rom_target),
        .step         (step_q),
        .x            (rom_x),
        .y            (rom_y),
        .exp_z        (rom_z),
        .valid_target (rom_valid),
        .n            (rom_n)
    );

`ifdef FSM_DRV_ZCHECK_EN
    assign z_mis = (fsm_z != Z_W'(rom_z));
`else
    logic unused_z;
    assign unused_z = ^{fsm_z, rom_z};
    assign z_mis    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // init_q keeps the controller in reset for the cycle after rst drops
    always_comb begin
        state_n   = state;
        req_ready = 1'b0;
        fsm_rst   = init_q;
        fsm_x     = 1'b0;
        fsm_y     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !init_q;
                if (req_valid && !init_q) state_n = rom_valid ? RESET : DONE;
            end
            RESET: begin
                fsm_rst = 1'b1;
                if (cnt_q == 4'(RST_PULSE - 1)) state_n = (rom_n != 2'd0) ? STEP : CHECK;
            end
            STEP: begin
                fsm_x = rom_x;
                fsm_y = rom_y;
                if (step_q == rom_n - 2'd1) state_n = CHECK;
            end
            CHECK: state_n = DONE;
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign accept = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            init_q   <= 1'b1;
            target_q <= 3'd0;
            cnt_q    <= 4'd0;
            step_q   <= 2'd0;
            mism_q   <= 1'b0;
            pass_q   <= 1'b0;
            bad_q    <= 1'b0;
            err_q    <= 2'd0;
        end else begin
            init_q <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    target_q <= req_target;
                    cnt_q    <= 4'd0;
                    step_q   <= 2'd0;
                    mism_q   <= 1'b0;
                    pass_q   <= 1'b0;
                    err_q    <= 2'd0;
                    bad_q    <= !rom_valid;
                end
                RESET: cnt_q <= cnt_q + 4'd1;
                STEP: begin
                    step_q <= step_q + 2'd1;
                    if (z_mis && !mism_q) begin
                        mism_q <= 1'b1;
                        err_q  <= step_q;
                    end
                end
                // step_q has advanced to N here, so a first mismatch reports N
                CHECK: begin
                    pass_q <= !(mism_q || z_mis);
                    if (z_mis && !mism_q) err_q <= step_q;
                end
                default: ;
            endcase
        end
    end

    assign pass       = pass_q;
    assign bad_target = bad_q;
    assign err_step   = err_q;

endmodule

// File: tb/tb_fsm_stim_driver.sv
// tb/tb_fsm_stim_driver.sv - self-checking bench for fsm_stim_driver with an attached x/y/z controller model
module tb_fsm_stim_driver;

    localparam int RP = 2;
    localparam int ZW = 3;
`ifdef FSM_DRV_ZCHECK_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic [2:0]    req_target = 3'd0;
    logic          req_ready, fsm_rst, fsm_x, fsm_y, done, pass, bad_target;
    logic [1:0]    err_step;
    logic [ZW-1:0] fsm_z;
    logic [2:0]    ctl = 3'd0;
    logic          force_en = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int last_done = -100;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fsm_stim_driver #(.RST_PULSE(RP), .Z_W(ZW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_target (req_target),
        .fsm_rst    (fsm_rst),
        .fsm_x      (fsm_x),
        .fsm_y      (fsm_y),
        .fsm_z      (fsm_z),
        .done       (done),
        .pass       (pass),
        .bad_target (bad_target),
        .err_step   (err_step)
    );

    function automatic logic [2:0] zof(input logic [2:0] s);
        case (s)
            3'd0: return 3'd0;
            3'd5: return 3'd0;
            3'd2: return 3'd1;
            3'd4: return 3'd1;
            3'd3: return 3'd2;
            3'd1: return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] ctl_next(input logic [2:0] s, input logic x, input logic y);
        case (s)
            3'd0: return y ? (x ? 3'd4 : 3'd5) : 3'd0;
            3'd5: return 3'd2;
            3'd2: return y ? 3'd1 : (x ? 3'd4 : 3'd3);
            3'd3: return 3'd1;
            default: return s;
        endcase
    endfunction

    always @(posedge clk) ctl <= fsm_rst ? 3'd0 : ctl_next(ctl, fsm_x, fsm_y);
    assign fsm_z = zof(ctl) ^ (force_en ? 3'b111 : 3'b000);

    // {x,y} steering path per target; n = -1 marks an illegal code
    task automatic get_path(input logic [2:0] tgt, output int n, output logic [1:0] p [3]);
        p[0] = 2'b00; p[1] = 2'b00; p[2] = 2'b00;
        case (tgt)
            3'd0: n = 0;
            3'd5: begin n = 1; p[0] = 2'b01; end
            3'd4: begin n = 1; p[0] = 2'b11; end
            3'd2: begin n = 2; p[0] = 2'b01; end
            3'd3: begin n = 3; p[0] = 2'b01; end
            3'd1: begin n = 3; p[0] = 2'b01; p[2] = 2'b01; end
            default: n = -1;
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_req(input logic [2:0] tgt, input int fstep, input bit hold,
                           input logic [2:0] nxt, input bit b2b);
        int n, lat, tcyc;
        logic [1:0] p [3];
        bit valid, got, seen, forced;
        logic exp_pass;
        logic [1:0] exp_err, xy;
        logic [4:0] expv;
        get_path(tgt, n, p);
        valid  = (n >= 0);
        forced = valid && (fstep <= n);
        got = 0;
        for (int w = 0; w < 40 && !got; w++) begin
            @(negedge clk);
            if (req_ready) got = 1;
        end
        if (!got) begin
            chk("ready_timeout", 32'(got), 32'd1);
            return;
        end
        req_valid  = 1'b1;
        req_target = tgt;
        tcyc = cyc;
        if (b2b) chk("b2b_accept_gap", 32'(tcyc - last_done), 32'd1);
        lat      = valid ? RP + n + 2 : 1;
        exp_pass = valid && !(ZC && forced);
        exp_err  = (ZC && forced) ? 2'(fstep) : 2'd0;
        @(posedge clk);
        #1;
        if (hold) req_target = nxt;
        else      req_valid  = 1'b0;
        seen = 0;
        for (int c = 1; c <= lat + 2 && !seen; c++) begin
            @(negedge clk);
            force_en = forced && (c == RP + 1 + fstep);
            xy = (valid && c > RP && c <= RP + n) ? p[c - RP - 1] : 2'b00;
            expv = {1'b0, valid && c <= RP, xy, c == lat};
            chk($sformatf("t%0d_cycle%0d_rdy_rst_x_y_done", tgt, c),
                32'({req_ready, fsm_rst, fsm_x, fsm_y, done}), 32'(expv));
            if (done) seen = 1;
        end
        force_en = 1'b0;
        chk($sformatf("t%0d_done_seen", tgt), 32'(seen), 32'd1);
        last_done = cyc;
        chk($sformatf("t%0d_pass_bad_err", tgt), 32'({pass, bad_target, err_step}),
            32'({exp_pass, !valid, exp_err}));
        if (!hold) begin
            @(negedge clk);
            chk($sformatf("t%0d_held_results", tgt), 32'({done, pass, bad_target, err_step}),
                32'({1'b0, exp_pass, !valid, exp_err}));
        end
    endtask

    initial begin
        logic [2:0] tgt;
        int f;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_values", 32'({req_ready, fsm_rst, fsm_x, fsm_y, done, pass, bad_target, err_step}),
            32'(9'b0_1000_0000));
        rst = 1'b0;
        #1;
        chk("ready_low_first_cycle", 32'({req_ready, fsm_rst}), 32'(2'b01));
        @(negedge clk);
        chk("ready_rises", 32'({req_ready, fsm_rst}), 32'(2'b10));

        run_req(3'd1, 9, 0, 3'd0, 0);
        run_req(3'd3, 2, 0, 3'd0, 0);
        run_req(3'd7, 9, 0, 3'd0, 0);
        run_req(3'd0, 9, 0, 3'd0, 0);
        run_req(3'd0, 0, 0, 3'd0, 0);
        run_req(3'd1, 3, 0, 3'd0, 0);
        run_req(3'd5, 0, 0, 3'd0, 0);

        // Abort an S5 request during its second step
        @(negedge clk);
        chk("abort_ready", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_target = 3'd2;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (RP + 2) @(negedge clk);
        chk("abort_in_step1", 32'({fsm_rst, fsm_x, fsm_y}), 32'(3'b000));
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outputs", 32'({req_ready, fsm_rst, fsm_x, fsm_y, done, pass, bad_target, err_step}),
            32'(9'b0_1000_0000));
        rst = 1'b0;
        @(negedge clk);
        chk("abort_recover", 32'({req_ready, fsm_rst, done}), 32'(3'b100));
        run_req(3'd4, 9, 0, 3'd0, 0);

        run_req(3'd5, 9, 1, 3'd4, 0);
        run_req(3'd4, 9, 0, 3'd0, 1);

        for (int i = 0; i < 24; i++) begin
            tgt = 3'($urandom_range(0, 7));
            f   = int'($urandom_range(0, 4));
            run_req(tgt, f, 0, 3'd0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
